// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase sequencer and the phase timer.
// Holds the 4-bit phase code layout, direction constants and helpers that map
// between (phase kind, direction) pairs and codes.
//   Code layout: ALL_RED = 0; for direction d, PRI_GREEN = 1+3d, EXT_GREEN = 2+3d,
//   YELLOW = 3+3d. Codes 13..15 are illegal.
package traffic_pkg;

  localparam logic [3:0] ALL_RED        = 4'd0;
  localparam logic [3:0] PRI_GREEN_BASE = 4'd1;
  localparam logic [3:0] EXT_GREEN_BASE = 4'd2;
  localparam logic [3:0] YELLOW_BASE    = 4'd3;
  localparam logic [3:0] PHASE_STRIDE   = 4'd3;
  localparam logic [3:0] LAST_CODE      = 4'd12;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    KindAllRed,
    KindPri,
    KindExt,
    KindYellow
  } phase_kind_e;

  function automatic logic [3:0] phase_code(phase_kind_e kind, logic [1:0] d);
    logic [3:0] base;
    case (kind)
      KindPri:    base = PRI_GREEN_BASE;
      KindExt:    base = EXT_GREEN_BASE;
      KindYellow: base = YELLOW_BASE;
      default:    base = ALL_RED;
    endcase
    return (kind == KindAllRed) ? ALL_RED : base + PHASE_STRIDE * {2'b00, d};
  endfunction

  // Illegal codes decode as all-red; callers check code_legal() separately.
  function automatic phase_kind_e code_kind(logic [3:0] code);
    phase_kind_e kind;
    case (code)
      4'd1, 4'd4, 4'd7, 4'd10: kind = KindPri;
      4'd2, 4'd5, 4'd8, 4'd11: kind = KindExt;
      4'd3, 4'd6, 4'd9, 4'd12: kind = KindYellow;
      default:                 kind = KindAllRed;
    endcase
    return kind;
  endfunction

  function automatic logic code_legal(logic [3:0] code);
    return code <= LAST_CODE;
  endfunction

endpackage

// File: rtl/cong_filter.sv
// Congestion filter for one approach.
// A saturating counter runs while the raw sensor is high and clears when it is low;
// the latch sets once the counter reaches CONG_CYCLES and holds until cleared.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   cong : raw congestion sensor
//   clr  : clear the latch (wins over a simultaneous set)
//   lat  : filtered, latched congestion flag
module cong_filter #(
  parameter int unsigned CONG_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cong,
  input  logic clr,
  output logic lat
);

  localparam int unsigned CntW = $clog2(CONG_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CONG_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (cong) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lat   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (clr) begin
        lat <= 1'b0;
      end else if (cnt_d == CntMax) begin
        lat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Phase sequencer for a 4-way intersection, feeding the phase timer.
// Steps ALL_RED -> green (primary or extended) -> YELLOW -> ALL_RED on timer expiry,
// rotating direction round-robin (optionally skipping approaches without demand).
// All outputs are registered; lamps are decoded from the next phase so they change
// together with `state`.
//   clk, rst   : clock, synchronous active-high reset
//   expired    : one-cycle timer expiry pulse
//   cong       : raw congestion sensors, bit d = direction d (0=N,1=E,2=S,3=W)
//   vehicle    : vehicle-present per direction
//   emerg_req  : emergency preemption request
//   emerg_dir  : direction requested by the emergency vehicle
//   state      : phase code to the timer
//   dir        : direction owning (or next to own) the phase
//   green, yellow, red : lamp outputs per direction
// Build option: define EMERGENCY_PREEMPT_EN to enable emergency preemption; otherwise
// emerg_req/emerg_dir are ignored.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned CONG_CYCLES = 3,
  parameter bit          SKIP_EMPTY  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       expired,
  input  logic [3:0] cong,
  input  logic [3:0] vehicle,
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
  output logic [3:0] state,
  output logic [1:0] dir,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red
);

  phase_kind_e kind, nxt_kind;
  logic        legal;
  logic [1:0]  nxt_dir, rr_dir, cand;
  logic [3:0]  cong_lat, lat_clr;
  logic [3:0]  nxt_green, nxt_yellow;

`ifndef EMERGENCY_PREEMPT_EN
  logic unused_emerg;
  assign unused_emerg = ^{emerg_req, emerg_dir};
`endif

  for (genvar d = 0; d < 4; d++) begin : g_cong
    cong_filter #(
      .CONG_CYCLES(CONG_CYCLES)
    ) u_cong_filter (
      .clk  (clk),
      .rst  (rst),
      .cong (cong[d]),
      .clr  (lat_clr[d]),
      .lat  (cong_lat[d])
    );
  end

  // Round-robin successor: scan dir+4 down to dir+1 so the nearest demand wins.
  always_comb begin
    rr_dir = dir + 2'd1;
    cand   = dir;
    if (SKIP_EMPTY) begin
      for (int k = 4; k >= 1; k--) begin
        cand = dir + 2'(k);
        if (vehicle[cand]) begin
          rr_dir = cand;
        end
      end
    end
  end

  always_comb begin
    kind     = code_kind(state);
    legal    = code_legal(state);
    nxt_kind = kind;
    nxt_dir  = dir;
    if (!legal) begin
      nxt_kind = KindAllRed;
    end else begin
      unique case (kind)
        KindAllRed: begin
`ifdef EMERGENCY_PREEMPT_EN
          if (emerg_req) begin
            nxt_dir = emerg_dir;
            if (expired) nxt_kind = KindPri;
          end else
`endif
          if (expired) nxt_kind = cong_lat[dir] ? KindExt : KindPri;
        end
        KindPri, KindExt: begin
`ifdef EMERGENCY_PREEMPT_EN
          // Cut a foreign green short; hold the emergency direction's green.
          if (emerg_req) begin
            if (emerg_dir != dir) nxt_kind = KindYellow;
          end else
`endif
          if (expired) nxt_kind = KindYellow;
        end
        KindYellow: begin
          if (expired) begin
            nxt_kind = KindAllRed;
            nxt_dir  = rr_dir;
`ifdef EMERGENCY_PREEMPT_EN
            if (emerg_req) nxt_dir = emerg_dir;
`endif
          end
        end
      endcase
    end
  end

  always_comb begin
    nxt_green  = (nxt_kind == KindPri || nxt_kind == KindExt) ? 4'b0001 << nxt_dir : 4'b0000;
    nxt_yellow = (nxt_kind == KindYellow) ? 4'b0001 << nxt_dir : 4'b0000;
    // Latch clears only on the entry edge into yellow of that direction.
    lat_clr    = (legal && kind != KindYellow && nxt_kind == KindYellow) ?
                 4'b0001 << nxt_dir : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ALL_RED;
      dir    <= DIR_N;
      green  <= 4'b0000;
      yellow <= 4'b0000;
      red    <= 4'b1111;
    end else begin
      state  <= phase_code(nxt_kind, nxt_dir);
      dir    <= nxt_dir;
      green  <= nxt_green;
      yellow <= nxt_yellow;
      red    <= ~(nxt_green | nxt_yellow);
    end
  end

endmodule

// File: doc/traffic_phase_fsm.md
Name: traffic_phase_fsm

Overview:
- Phase sequencer for a 4-way intersection; directly upstream of the phase timer.
- Drives the 4-bit `state` code the timer decodes into a duration, and consumes the timer's one-cycle `expired` pulse to advance.
- Filters per-direction congestion sensors to choose primary vs extended green, and skips empty approaches.
- Decodes per-direction red/yellow/green lamp outputs.

Parameters:
- CONG_CYCLES, 3: consecutive cycles `cong[d]` must be high to latch congestion for direction d (1..15).
- SKIP_EMPTY, 1: 1 = round-robin skips directions with no `vehicle` demand; 0 = strict rotation.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- expired  input  1  one-cycle timer expiry pulse
- cong  input  4  raw congestion sensor per direction (0=N,1=E,2=S,3=W)
- vehicle  input  4  vehicle-present per direction
- emerg_req  input  1  emergency preemption request (used only with feature)
- emerg_dir  input  2  direction requested by emergency vehicle
- state  output  4  phase code to timer
- dir  output  2  direction currently owning (or next to own) the phase
- green  output  4  green lamp per direction
- yellow  output  4  yellow lamp per direction
- red  output  4  red lamp per direction

Behaviour:
- State codes: ALL_RED=0; for direction d: PRI_GREEN=1+3d, EXT_GREEN=2+3d, YELLOW=3+3d (codes 1..12).
- Reset (sync on posedge clk with rst=1):
  - `state`=0, `dir`=0, `green`=0, `yellow`=0, `red`=4'b1111.
  - Congestion counters and latches cleared.
  - Reset mid-phase is immediate and behaves identically.
- All outputs are registered. Lamps are decoded from the registered next state, so lamps and `state` change in the same cycle.
- Transitions occur only on a cycle with `expired`=1, except preemption.
- ALL_RED --expired--> EXT_GREEN(dir) if `cong_lat[dir]`=1, else PRI_GREEN(dir).
  - Decision uses the registered latch only; a latch setting in the same cycle is not seen.
- PRI_GREEN/EXT_GREEN --expired--> YELLOW(dir).
- YELLOW --expired--> ALL_RED, and `dir` advances:
  - SKIP_EMPTY=1: next direction after `dir` (mod 4, searching dir+1, dir+2, dir+3, dir) with `vehicle`=1.
  - If no direction has demand: dir+1 mod 4.
  - SKIP_EMPTY=0: always dir+1 mod 4; wraps 3→0.
- Illegal codes 13..15 go to ALL_RED on the next cycle, `dir` unchanged, regardless of `expired`.
- Congestion filter, per direction:
  - Saturating counter increments while `cong[d]`=1 and clears when `cong[d]`=0.
  - Latch sets when the counter reaches CONG_CYCLES.
  - Latch clears on the cycle the FSM enters YELLOW(d). Clear wins over a simultaneous set.
- Lamps:
  - Direction d is green in PRI/EXT_GREEN(d), yellow in YELLOW(d), otherwise red.
  - Exactly one of red/yellow/green is high per direction.
  - At most one direction is non-red.
- `state` holds at least one cycle after every change, since the timer reloads on a change.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN.
- Defined, while `emerg_req`=1:
  - In green of a direction ≠ `emerg_dir`: go to YELLOW(dir) next cycle without waiting for `expired`.
  - From ALL_RED after that yellow: `dir` is loaded with `emerg_dir` (not round-robin); enter PRI_GREEN(emerg_dir) on `expired`.
  - In green of `emerg_dir`: `expired` is ignored (green held).
  - In YELLOW: normal progression continues.
  - On `emerg_req` falling, normal operation resumes at the next `expired`.
- Undefined: `emerg_req`/`emerg_dir` ports remain but are ignored; no preemption logic is synthesised.

Decomposition:
- traffic_pkg holds:
  - state code localparams (ALL_RED, PRI_GREEN_BASE, EXT_GREEN_BASE, YELLOW_BASE, stride 3);
  - direction constants N/E/S/W;
  - a function mapping (phase kind, dir) to code.
- The timer shares this package.
- One sub-module, cong_filter: per-direction counter plus latch with a clear input, instantiated 4×.

Test Plan:
- Reset, then `expired` pulses with `vehicle`=4'b1111, `cong`=0 → `state` 0→1→3→0→4→6→0→7→9→0→10→12→0→1; `dir` 0,0,0,1,1,1,2,…,0.
- `cong[1]` high 3 cycles before ALL_RED expiry with `dir`=1 → `state`=5 (EXT_GREEN E). `cong[1]` high only 2 cycles → `state`=4. Latch clears on entering state 6.
- `vehicle`=4'b0100, SKIP_EMPTY=1, YELLOW(0) expires → `dir`=2, next green `state`=7. With `vehicle`=0 → `dir`=1.
- Force `state` to 14 via `force`/`release` → next cycle `state`=0, lamps all red. `rst` asserted during `state`=5 → next cycle `state`=0, `dir`=0.
- Check every cycle: at most one of `green`|`yellow` is nonzero in a single direction, and per-direction one-hot lamps hold.
- EMERGENCY_PREEMPT_EN: in `state`=1, `emerg_req`=1, `emerg_dir`=3 → next cycle `state`=3; on expiries `state`=0 then `state`=10; 50 further `expired` pulses leave `state`=10 until `emerg_req` drops.
